// File: rtl/div_scheduler.sv
// Shared-divider scheduler: round-robin arbitration of two requesters onto a
// signed/unsigned iterative divider pair, with divide-by-zero bypass and busy timeout.
module div_scheduler #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic             i_sgn0,
  input  logic             i_sgn1,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_b0,
  input  logic [WIDTH-1:0] i_b1,
  output logic             o_ack0,
  output logic             o_ack1,
  output logic             o_done0,
  output logic             o_done1,
  output logic [WIDTH-1:0] o_q_out,
  output logic [WIDTH-1:0] o_r_out,
  output logic             o_dz,
  output logic             o_err,
  output logic [WIDTH-1:0] o_div_dividend,
  output logic [WIDTH-1:0] o_div_divisor,
  output logic             o_div_start,
  output logic             o_divu_start,
  input  logic             i_div_busy,
  input  logic             i_divu_busy,
  input  logic [WIDTH-1:0] i_div_q,
  input  logic [WIDTH-1:0] i_div_r,
  input  logic [WIDTH-1:0] i_divu_q,
  input  logic [WIDTH-1:0] i_divu_r
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT_HI, S_WAIT_LO, S_RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_last_gnt, w_last_nxt;
  logic             r_owner, w_owner_nxt;
  logic             r_sgn, w_sgn_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_dividend, w_dividend_nxt;
  logic [WIDTH-1:0] r_divisor, w_divisor_nxt;
  logic [WIDTH-1:0] r_q_out, w_q_nxt;
  logic [WIDTH-1:0] r_r_out, w_r_nxt;
  logic             r_dz, w_dz_nxt;
  logic             r_err, w_err_nxt;
  logic             r_ack0, r_ack1, w_ack0_nxt, w_ack1_nxt;
  logic             r_done0, r_done1;
  logic             r_div_start, r_divu_start, w_div_start_nxt, w_divu_start_nxt;
  logic             w_fin;
  logic             w_gnt;
  logic             w_sel_busy;
  logic             w_timeout;
  logic             w_sgn_sel;
  logic [WIDTH-1:0] w_a_sel, w_b_sel, w_sel_q, w_sel_r;

  // Tie goes to the requester not served last
  assign w_gnt      = (i_req0 & i_req1) ? ~r_last_gnt : i_req1;
  assign w_a_sel    = w_gnt ? i_a1 : i_a0;
  assign w_b_sel    = w_gnt ? i_b1 : i_b0;
  assign w_sgn_sel  = w_gnt ? i_sgn1 : i_sgn0;
  assign w_sel_busy = r_sgn ? i_div_busy : i_divu_busy;
  assign w_sel_q    = r_sgn ? i_div_q : i_divu_q;
  assign w_sel_r    = r_sgn ? i_div_r : i_divu_r;
  assign w_timeout  = (r_cnt >= CW'(TIMEOUT - 1));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state plus next values of every registered output/datapath flop
  always_comb begin
    w_state_nxt      = r_state;
    w_last_nxt       = r_last_gnt;
    w_owner_nxt      = r_owner;
    w_sgn_nxt        = r_sgn;
    w_cnt_nxt        = r_cnt;
    w_dividend_nxt   = r_dividend;
    w_divisor_nxt    = r_divisor;
    w_q_nxt          = r_q_out;
    w_r_nxt          = r_r_out;
    w_dz_nxt         = r_dz;
    w_err_nxt        = r_err;
    w_ack0_nxt       = 1'b0;
    w_ack1_nxt       = 1'b0;
    w_div_start_nxt  = 1'b0;
    w_divu_start_nxt = 1'b0;
    w_fin            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req0 | i_req1) begin
          w_owner_nxt      = w_gnt;
          w_last_nxt       = w_gnt;
          w_sgn_nxt        = w_sgn_sel;
          w_dividend_nxt   = w_a_sel;
          w_divisor_nxt    = w_b_sel;
          w_ack0_nxt       = ~w_gnt;
          w_ack1_nxt       = w_gnt;
          w_div_start_nxt  = (|w_b_sel) & w_sgn_sel;
          w_divu_start_nxt = (|w_b_sel) & ~w_sgn_sel;
          w_dz_nxt         = 1'b0;
          w_err_nxt        = 1'b0;
          w_state_nxt      = S_START;
        end
      end
      S_START: begin
        if (~|r_divisor) begin
          w_q_nxt     = '1;
          w_r_nxt     = r_dividend;
          w_dz_nxt    = 1'b1;
          w_fin       = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_timeout) begin
          w_q_nxt     = '0;
          w_r_nxt     = '0;
          w_err_nxt   = 1'b1;
          w_fin       = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_sel_busy) begin
          w_state_nxt = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (!w_sel_busy) begin
          w_q_nxt     = w_sel_q;
          w_r_nxt     = w_sel_r;
          w_fin       = 1'b1;
          w_state_nxt = S_RESP;
        end else if (w_timeout) begin
          w_q_nxt     = '0;
          w_r_nxt     = '0;
          w_err_nxt   = 1'b1;
          w_fin       = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_last_gnt   <= 1'b1;
      r_owner      <= 1'b0;
      r_sgn        <= 1'b0;
      r_cnt        <= '0;
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_q_out      <= '0;
      r_r_out      <= '0;
      r_dz         <= 1'b0;
      r_err        <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_div_start  <= 1'b0;
      r_divu_start <= 1'b0;
    end else begin
      r_last_gnt   <= w_last_nxt;
      r_owner      <= w_owner_nxt;
      r_sgn        <= w_sgn_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dividend   <= w_dividend_nxt;
      r_divisor    <= w_divisor_nxt;
      r_q_out      <= w_q_nxt;
      r_r_out      <= w_r_nxt;
      r_dz         <= w_dz_nxt;
      r_err        <= w_err_nxt;
      r_ack0       <= w_ack0_nxt;
      r_ack1       <= w_ack1_nxt;
      r_done0      <= w_fin & ~r_owner;
      r_done1      <= w_fin & r_owner;
      r_div_start  <= w_div_start_nxt;
      r_divu_start <= w_divu_start_nxt;
    end
  end

  assign o_ack0         = r_ack0;
  assign o_ack1         = r_ack1;
  assign o_done0        = r_done0;
  assign o_done1        = r_done1;
  assign o_q_out        = r_q_out;
  assign o_r_out        = r_r_out;
  assign o_dz           = r_dz;
  assign o_err          = r_err;
  assign o_div_dividend = r_dividend;
  assign o_div_divisor  = r_divisor;
  assign o_div_start    = r_div_start;
  assign o_divu_start   = r_divu_start;

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: behavioural divider cores, arithmetic reference model,
// directed and random operations with latency/result checks.
module tb_div_scheduler;
  localparam int unsigned W  = 32;
  localparam int unsigned TO = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic req0, req1, sgn0, sgn1;
  logic [W-1:0] a0, a1, b0, b1;
  logic ack0, ack1, done0, done1, dz, err, div_start, divu_start;
  logic [W-1:0] q_out, r_out, dvd, dvs;
  logic div_busy, divu_busy;
  logic [W-1:0] div_q, div_r, divu_q, divu_r;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int core_lat = 3;
  bit core_hang = 1'b0;
  int div_starts = 0;
  int divu_starts = 0;
  bit m_last = 1'b1;

  always #5 clk = ~clk;

  div_scheduler #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_req0(req0), .i_req1(req1), .i_sgn0(sgn0), .i_sgn1(sgn1),
    .i_a0(a0), .i_a1(a1), .i_b0(b0), .i_b1(b1),
    .o_ack0(ack0), .o_ack1(ack1), .o_done0(done0), .o_done1(done1),
    .o_q_out(q_out), .o_r_out(r_out), .o_dz(dz), .o_err(err),
    .o_div_dividend(dvd), .o_div_divisor(dvs),
    .o_div_start(div_start), .o_divu_start(divu_start),
    .i_div_busy(div_busy), .i_divu_busy(divu_busy),
    .i_div_q(div_q), .i_div_r(div_r), .i_divu_q(divu_q), .i_divu_r(divu_r)
  );

  always @(posedge clk) begin
    if (div_start)  div_starts++;
    if (divu_start) divu_starts++;
  end

  // Behavioural cores: busy for core_lat cycles after start, junk results until done
  int s_cnt, u_cnt;
  logic [W-1:0] s_pq, s_pr, u_pq, u_pr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_busy <= 1'b0; s_cnt <= 0; div_q <= '0; div_r <= '0;
    end else if (div_start && !core_hang) begin
      div_busy <= 1'b1;
      s_cnt <= core_lat - 1;
      if (dvs != '0) begin
        s_pq <= W'($signed(dvd) / $signed(dvs));
        s_pr <= W'($signed(dvd) % $signed(dvs));
      end
      div_q <= W'($urandom);
      div_r <= W'($urandom);
    end else if (div_busy) begin
      if (s_cnt == 0) begin
        div_busy <= 1'b0; div_q <= s_pq; div_r <= s_pr;
      end else s_cnt <= s_cnt - 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divu_busy <= 1'b0; u_cnt <= 0; divu_q <= '0; divu_r <= '0;
    end else if (divu_start && !core_hang) begin
      divu_busy <= 1'b1;
      u_cnt <= core_lat - 1;
      if (dvs != '0) begin
        u_pq <= dvd / dvs;
        u_pr <= dvd % dvs;
      end
      divu_q <= W'($urandom);
      divu_r <= W'($urandom);
    end else if (divu_busy) begin
      if (u_cnt == 0) begin
        divu_busy <= 1'b0; divu_q <= u_pq; divu_r <= u_pr;
      end else u_cnt <= u_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic void ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output bit z);
    z = (b == '0);
    if (z) begin
      q = '1; r = a;
    end else if (s) begin
      q = W'($signed(a) / $signed(b)); r = W'($signed(a) % $signed(b));
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Serve one already-raised request: ack, drop req, await done, check against model
  task automatic serve(input bit who);
    bit s, ez;
    logic [W-1:0] a, b, eq, er;
    int t, ack_c, exp_d, ds, dus;
    s = who ? sgn1 : sgn0;
    a = who ? a1 : a0;
    b = who ? b1 : b0;
    ref_div(s, a, b, eq, er, ez);
    if (core_hang && !ez) begin
      eq = '0; er = '0;
    end
    exp_d = ez ? 1 : (core_hang ? TO + 1 : core_lat + 2);
    t = 0;
    while (!(who ? ack1 : ack0) && t < 200) begin step(); t++; end
    chk("ack_seen", 64'(who ? ack1 : ack0), 64'd1);
    chk("ack_lat", 64'(t), 64'd1);
    chk("ack_other", 64'(who ? ack0 : ack1), 64'd0);
    chk("dividend", 64'(dvd), 64'(a));
    chk("divisor", 64'(dvs), 64'(b));
    ack_c = cyc; ds = div_starts; dus = divu_starts;
    m_last = who;
    if (who) req1 = 1'b0; else req0 = 1'b0;
    t = 0;
    while (!(who ? done1 : done0) && t < TO + 50) begin
      step(); t++;
      chk("done_other", 64'(who ? done0 : done1), 64'd0);
    end
    chk("done_seen", 64'(who ? done1 : done0), 64'd1);
    chk("done_lat", 64'(cyc - ack_c), 64'(exp_d));
    chk("q_out", 64'(q_out), 64'(eq));
    chk("r_out", 64'(r_out), 64'(er));
    chk("dz", 64'(dz), 64'(ez));
    chk("err", 64'(err), 64'(core_hang && !ez));
    chk("div_starts", 64'(div_starts - ds), 64'(!ez && s));
    chk("divu_starts", 64'(divu_starts - dus), 64'(!ez && !s));
    step();
    chk("done_pulse", 64'(who ? done1 : done0), 64'd0);
    chk("q_hold", 64'(q_out), 64'(eq));
  endtask

  task automatic issue(input bit who, input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    if (who) begin sgn1 = s; a1 = a; b1 = b; req1 = 1'b1; end
    else     begin sgn0 = s; a0 = a; b0 = b; req0 = 1'b1; end
    serve(who);
  endtask

  task automatic pair(input bit s0, input logic [W-1:0] pa0, input logic [W-1:0] pb0,
                      input bit s1, input logic [W-1:0] pa1, input logic [W-1:0] pb1);
    bit first;
    sgn0 = s0; a0 = pa0; b0 = pb0;
    sgn1 = s1; a1 = pa1; b1 = pb1;
    req0 = 1'b1; req1 = 1'b1;
    first = ~m_last;
    serve(first);
    serve(~first);
  endtask

  initial begin
    bit who, s;
    logic [W-1:0] a, b;
    rst_n = 1'b0;
    req0 = 0; req1 = 0; sgn0 = 0; sgn1 = 0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    step(); step();
    chk("rst_q", 64'(q_out), 64'd0);
    chk("rst_acks", 64'({ack0, ack1, done0, done1}), 64'd0);
    chk("rst_starts", 64'({div_start, divu_start, dz, err}), 64'd0);
    chk("rst_opnd", 64'({dvd, dvs}), 64'd0);
    rst_n = 1'b1;

    // Tie straight out of reset: req0 first
    core_lat = 3;
    pair(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555);

    issue(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2);
    chk("tp_uq", 64'(q_out), 64'h7FFF_FFFF);
    chk("tp_ur", 64'(r_out), 64'd1);
    core_lat = 5;
    issue(1'b1, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
    chk("tp_sq", 64'(q_out), 64'hFFFF_FFFF);
    chk("tp_sr", 64'(r_out), 64'hFFFF_FFFF);

    // Last served was req1 -> serve req0 alone so the next tie goes to req1
    issue(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
    pair(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, 32'd1000, 32'd33);

    issue(1'b0, 1'b0, 32'h1234_5678, 32'd0);
    chk("dz_q", 64'(q_out), 64'hFFFF_FFFF);
    chk("dz_r", 64'(r_out), 64'h1234_5678);
    chk("dz_flag", 64'(dz), 64'd1);

    core_hang = 1'b1;
    issue(1'b0, 1'b0, 32'd77, 32'd5);
    core_hang = 1'b0;
    issue(1'b1, 1'b0, 32'd77, 32'd5);

    for (int i = 0; i < 24; i++) begin
      who = 1'($urandom);
      s = 1'($urandom);
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom >> $urandom_range(0, 28));
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      core_lat = $urandom_range(1, 8);
      issue(who, s, a, b);
    end

    // Reset in WAIT_LO aborts the operation without a done
    core_lat = 10;
    sgn0 = 1'b0; a0 = 32'd999; b0 = 32'd3; req0 = 1'b1;
    step();
    chk("rstop_ack", 64'(ack0), 64'd1);
    req0 = 1'b0;
    step(); step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("rstop_q", 64'({q_out, r_out}), 64'd0);
    chk("rstop_ctl", 64'({ack0, ack1, done0, done1, div_start, divu_start, dz, err}), 64'd0);
    chk("rstop_opnd", 64'({dvd, dvs}), 64'd0);
    m_last = 1'b1;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("rstop_nodone", 64'({done0, done1}), 64'd0);
    end
    core_lat = 4;
    pair(1'b0, 32'd50, 32'd6, 1'b1, 32'hFFFF_FFCE, 32'd6);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
